rc4_stream_encrypter: RTL

- Streaming RC4 PRGA encrypter. It is the transmit-side counterpart of the decrypter: it XORs plaintext with the keystream drawn from the shared 256x8 S-box SRAM.
- Plaintext bytes arrive on a valid/ready input. Ciphertext bytes leave on a valid/ready output.
- It sits after the key-schedule block, which has already loaded S, and owns the S SRAM port while busy.

---
 rtl/rc4_stream_encrypter.sv | 298 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rc4_stream_encrypter.sv
// rc4_stream_encrypter
// -----------------------------------------------------------------------------
// Streaming RC4 PRGA encrypter. Each plaintext byte accepted on the pt_*
// channel is XORed with the next RC4 keystream byte and sent out on the ct_*
// channel. The keystream is generated in place in an external 256x8 S-box
// SRAM that a key-schedule block has already loaded; this block owns the SRAM
// port while busy. Exactly one byte is in flight at a time.
//
// Handshakes (both channels): a byte moves on a rising clk edge where
// valid && ready are both high. A producer holds valid and data stable until
// that edge and never drops valid without a transfer; ready may change freely
// and ready without valid has no effect.
//
// SRAM protocol: reads register addr_s and sample q_s two edges later
// (SET, WAIT, READ). Writes present addr_s/char_s one cycle ahead of a
// single-cycle wren_s pulse and keep them for the cycle after it.
//
// Parameters:
//   MSG_LEN  bytes encrypted per start (1..256)
//   DROP_N   keystream bytes discarded before the first plaintext byte
//            (only with RC4_DROP_EN defined)
//
// Optional feature macro: RC4_DROP_EN
//   defined   - after start, DROP_N full PRGA iterations run with the keystream
//               byte thrown away before the first plaintext byte is accepted
//   undefined - no drop phase; DROP_N is unused
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset (aborts any message at once)
//   start      level; begins a message when high in IDLE
//   done       high in DONE
//   busy       high in every state except IDLE and DONE
//   q_s        S SRAM read data
//   addr_s     S SRAM address
//   char_s     S SRAM write data
//   wren_s     S SRAM write enable
//   pt_data    plaintext byte
//   pt_valid   plaintext valid
//   pt_ready   plaintext ready (high only while waiting for a byte)
//   ct_data    ciphertext byte
//   ct_valid   ciphertext valid
//   ct_ready   downstream ready
//   state_dbg  current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module rc4_stream_encrypter #(
  parameter int MSG_LEN = 32,
  parameter int DROP_N  = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic       busy,
  input  logic [7:0] q_s,
  output logic [7:0] addr_s,
  output logic [7:0] char_s,
  output logic       wren_s,
  input  logic [7:0] pt_data,
  input  logic       pt_valid,
  output logic       pt_ready,
  output logic [7:0] ct_data,
  output logic       ct_valid,
  input  logic       ct_ready,
  output logic [4:0] state_dbg
);

  typedef enum logic [4:0] {
    IDLE,
    GET_PT,
    STEP,
    SI_SET,
    SI_WAIT,
    SI_READ,
    J_UPD,
    SJ_SET,
    SJ_WAIT,
    SJ_READ,
    WJ_SETUP,
    WJ_WREN,
    WJ_HOLD,
    WI_SETUP,
    WI_WREN,
    WI_HOLD,
    F_CALC,
    F_SET,
    F_WAIT,
    F_READ,
    EMIT,
    WAIT_CT,
    DONE
  } state_t;

  localparam logic [8:0] LAST_CNT = 9'(MSG_LEN - 1);

  state_t     state;
  logic [7:0] i;
  logic [7:0] j;
  logic [7:0] si;
  logic [7:0] sj;
  logic [7:0] f;
  logic [7:0] faddr;
  logic [7:0] pt_reg;
  logic [8:0] cnt;

`ifdef RC4_DROP_EN
  localparam logic [8:0] DROP_LAST = 9'(DROP_N - 1);
  logic [8:0] drop_cnt;
  logic       dropping;
`else
  // DROP_N has no function without the drop phase.
  logic [8:0] drop_unused;
  assign drop_unused = 9'(DROP_N);
`endif

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      i        <= 8'd0;
      j        <= 8'd0;
      si       <= 8'd0;
      sj       <= 8'd0;
      f        <= 8'd0;
      faddr    <= 8'd0;
      pt_reg   <= 8'd0;
      cnt      <= 9'd0;
      addr_s   <= 8'd0;
      char_s   <= 8'd0;
      wren_s   <= 1'b0;
      pt_ready <= 1'b0;
      ct_valid <= 1'b0;
      ct_data  <= 8'd0;
      done     <= 1'b0;
      busy     <= 1'b0;
`ifdef RC4_DROP_EN
      drop_cnt <= 9'd0;
      dropping <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          i   <= 8'd0;
          j   <= 8'd0;
          cnt <= 9'd0;
          if (start) begin
            busy <= 1'b1;
`ifdef RC4_DROP_EN
            drop_cnt <= 9'd0;
            if (DROP_N == 0) begin
              pt_ready <= 1'b1;
              state    <= GET_PT;
            end else begin
              dropping <= 1'b1;
              state    <= STEP;
            end
`else
            pt_ready <= 1'b1;
            state    <= GET_PT;
`endif
          end
        end

        GET_PT: begin
          if (pt_valid && pt_ready) begin
            pt_reg   <= pt_data;
            pt_ready <= 1'b0;
            state    <= STEP;
          end
        end

        STEP: begin
          i     <= i + 8'd1;
          state <= SI_SET;
        end

        SI_SET: begin
          addr_s <= i;
          state  <= SI_WAIT;
        end
        SI_WAIT: state <= SI_READ;
        SI_READ: begin
          si    <= q_s;
          state <= J_UPD;
        end

        J_UPD: begin
          j     <= j + si;
          state <= SJ_SET;
        end

        SJ_SET: begin
          addr_s <= j;
          state  <= SJ_WAIT;
        end
        SJ_WAIT: state <= SJ_READ;
        SJ_READ: begin
          sj    <= q_s;
          state <= WJ_SETUP;
        end

        // Swap: S[j] <= si, then S[i] <= sj. With i == j both land on the
        // same address and si == sj, so the order is harmless.
        WJ_SETUP: begin
          addr_s <= j;
          char_s <= si;
          state  <= WJ_WREN;
        end
        WJ_WREN: begin
          wren_s <= 1'b1;
          state  <= WJ_HOLD;
        end
        WJ_HOLD: begin
          wren_s <= 1'b0;
          state  <= WI_SETUP;
        end

        WI_SETUP: begin
          addr_s <= i;
          char_s <= sj;
          state  <= WI_WREN;
        end
        WI_WREN: begin
          wren_s <= 1'b1;
          state  <= WI_HOLD;
        end
        WI_HOLD: begin
          wren_s <= 1'b0;
          state  <= F_CALC;
        end

        F_CALC: begin
          faddr <= si + sj; // carry out of bit 7 is dropped (mod 256)
          state <= F_SET;
        end

        F_SET: begin
          addr_s <= faddr;
          state  <= F_WAIT;
        end
        F_WAIT: state <= F_READ;
        F_READ: begin
          f     <= q_s;
          state <= EMIT;
        end

        EMIT: begin
`ifdef RC4_DROP_EN
          if (dropping) begin
            drop_cnt <= drop_cnt + 9'd1;
            if (drop_cnt == DROP_LAST) begin
              dropping <= 1'b0;
              pt_ready <= 1'b1;
              state    <= GET_PT;
            end else begin
              state <= STEP;
            end
          end else begin
            ct_data  <= pt_reg ^ f;
            ct_valid <= 1'b1;
            state    <= WAIT_CT;
          end
`else
          ct_data  <= pt_reg ^ f;
          ct_valid <= 1'b1;
          state    <= WAIT_CT;
`endif
        end

        WAIT_CT: begin
          if (ct_ready) begin
            ct_valid <= 1'b0;
            cnt      <= cnt + 9'd1;
            if (cnt == LAST_CNT) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              pt_ready <= 1'b1;
              state    <= GET_PT;
            end
          end
        end

        DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
